// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared FSM encodings and stall-reason codes for the hazard unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [0:0] {
        L_IDLE = 1'b0,
        L_WAIT = 1'b1
    } ld_state_t;

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_BUSY = 1'b1
    } md_state_t;

    localparam logic [1:0] c_reason_none = 2'b00;
    localparam logic [1:0] c_reason_load = 2'b01;
    localparam logic [1:0] c_reason_md   = 2'b10;
    localparam logic [1:0] c_reason_both = 2'b11;

endpackage

`default_nettype wire

// File: rtl/md_tracker.sv
// ============================================================================
// Module : md_tracker
// Brief  : Tracks one in-flight mul/div: busy window, done pulse, overlap flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    output logic md_busy,
    output logic md_done,
    output logic md_overlap_err
);

    localparam int                c_cnt_w  = $clog2(MD_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_md_lat = c_cnt_w'(MD_LAT);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    md_state_t            r_state;
    md_state_t            w_state_next;
    logic [c_cnt_w-1:0]   r_md_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 r_done;
    logic                 w_done_next;
    logic                 r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= M_IDLE;
            r_md_cnt <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_cnt_next;
            r_done   <= w_done_next;
            // A second issue while busy is dropped but remembered.
            if (md_start && (r_state == M_BUSY))
                r_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_md_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (md_start) begin
                    w_state_next = M_BUSY;
                    w_cnt_next   = c_md_lat;
                end
            end
            M_BUSY: begin
                w_cnt_next = r_md_cnt - c_one;
                if (r_md_cnt == c_one) begin
                    w_state_next = M_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = M_IDLE;
        endcase
    end

    assign md_busy        = (r_state == M_BUSY);
    assign md_done        = r_done;
    assign md_overlap_err = r_err;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Brief  : Load-use and mul/div interlock, branch flush, stall perf counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 32,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_memread,
    input  logic [AW-1:0]    id_ex_rd,
    input  logic [AW-1:0]    if_id_rs,
    input  logic [AW-1:0]    if_id_rt,
    input  logic             if_id_use_rs,
    input  logic             if_id_use_rt,
    input  logic             if_id_md_use,
    input  logic             md_start,
    input  logic             branch_taken,
    input  logic             cnt_clr,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [1:0]       stall_reason,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_overlap_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int                c_ld_w     = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [c_ld_w-1:0] c_ld_init  = c_ld_w'(LOAD_LAT - 1);
    localparam logic [c_ld_w-1:0] c_ld_one   = c_ld_w'(1);
    localparam bit                c_multi_ld = (LOAD_LAT > 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    ld_state_t          r_ld_state;
    ld_state_t          w_ld_next;
    logic [c_ld_w-1:0]  r_ld_cnt;
    logic [c_ld_w-1:0]  w_ld_cnt_next;
    logic [AW-1:0]      r_pend_rd;
    logic [AW-1:0]      w_pend_next;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_load_hit;
    logic w_pend_used;
    logic w_load_cause;
    logic w_md_cause;
    logic w_stall_ok;
    logic w_stall;
    logic w_flush;

    assign w_load_hit = id_ex_memread && (id_ex_rd != '0) &&
                        ((if_id_use_rs && (if_id_rs == id_ex_rd)) ||
                         (if_id_use_rt && (if_id_rt == id_ex_rd)));

    assign w_pend_used = (if_id_use_rs && (if_id_rs == r_pend_rd)) ||
                         (if_id_use_rt && (if_id_rt == r_pend_rd));

    assign w_load_cause = w_load_hit || ((r_ld_state == L_WAIT) && w_pend_used);
    assign w_md_cause   = md_busy && if_id_md_use;

    // Reset and a taken branch both suppress the interlock; flush wins over stall.
    assign w_stall_ok = rst_n && !branch_taken;
    assign w_stall    = w_stall_ok && (w_load_cause || w_md_cause);
    assign w_flush    = rst_n && branch_taken;

    assign stall        = w_stall;
    assign pc_write     = !w_stall;
    assign if_id_write  = !w_stall;
    assign id_ex_bubble = w_stall || w_flush;
    assign if_id_flush  = w_flush;
    assign stall_reason = w_stall_ok ? {w_md_cause, w_load_cause} : c_reason_none;
    assign stall_cnt    = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_state <= L_IDLE;
            r_ld_cnt   <= '0;
            r_pend_rd  <= '0;
        end else begin
            r_ld_state <= w_ld_next;
            r_ld_cnt   <= w_ld_cnt_next;
            r_pend_rd  <= w_pend_next;
        end
    end

    always_comb begin
        w_ld_next     = r_ld_state;
        w_ld_cnt_next = r_ld_cnt;
        w_pend_next   = r_pend_rd;
        if (branch_taken) begin
            w_ld_next = L_IDLE;
        end else begin
            case (r_ld_state)
                L_IDLE: begin
                    // A single-cycle load latency is covered by the hit cycle alone.
                    if (w_load_hit && c_multi_ld) begin
                        w_ld_next     = L_WAIT;
                        w_ld_cnt_next = c_ld_init;
                        w_pend_next   = id_ex_rd;
                    end
                end
                L_WAIT: begin
                    w_ld_cnt_next = r_ld_cnt - c_ld_one;
                    if (r_ld_cnt == c_ld_one)
                        w_ld_next = L_IDLE;
                end
                default: w_ld_next = L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (cnt_clr)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != c_cnt_max))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    md_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md_tracker (
        .clk            (clk),
        .rst_n          (rst_n),
        .md_start       (md_start),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .md_overlap_err (md_overlap_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Directed + random bench for two hazard_ctrl configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_ex_memread;
    logic [AW-1:0] id_ex_rd;
    logic [AW-1:0] if_id_rs;
    logic [AW-1:0] if_id_rt;
    logic          if_id_use_rs;
    logic          if_id_use_rt;
    logic          if_id_md_use;
    logic          md_start;
    logic          branch_taken;
    logic          cnt_clr;

    logic          stall_o       [2];
    logic          pc_write_o    [2];
    logic          if_id_write_o [2];
    logic          bubble_o      [2];
    logic          flush_o       [2];
    logic [1:0]    reason_o      [2];
    logic          busy_o        [2];
    logic          done_o        [2];
    logic          err_o         [2];
    logic [3:0]    cnt_o         [2];

    int tests = 0;
    int fails = 0;

    // Instance 0: LOAD_LAT=1, MD_LAT=4; instance 1: LOAD_LAT=3, MD_LAT=6.
    int ll_p [2] = '{1, 3};
    int md_p [2] = '{4, 6};

    // Reference model: remaining extra load-stall cycles, remaining busy cycles.
    int m_ld_left [2];
    int m_ld_reg  [2];
    int m_md_left [2];
    int m_done    [2];
    int m_err     [2];
    int m_cnt     [2];
    int e_stall   [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.AW(AW), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_use_rs(if_id_use_rs),
        .if_id_use_rt(if_id_use_rt), .if_id_md_use(if_id_md_use), .md_start(md_start),
        .branch_taken(branch_taken), .cnt_clr(cnt_clr), .stall(stall_o[0]),
        .pc_write(pc_write_o[0]), .if_id_write(if_id_write_o[0]), .id_ex_bubble(bubble_o[0]),
        .if_id_flush(flush_o[0]), .stall_reason(reason_o[0]), .md_busy(busy_o[0]),
        .md_done(done_o[0]), .md_overlap_err(err_o[0]), .stall_cnt(cnt_o[0])
    );

    hazard_ctrl #(.AW(AW), .LOAD_LAT(3), .MD_LAT(6), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_use_rs(if_id_use_rs),
        .if_id_use_rt(if_id_use_rt), .if_id_md_use(if_id_md_use), .md_start(md_start),
        .branch_taken(branch_taken), .cnt_clr(cnt_clr), .stall(stall_o[1]),
        .pc_write(pc_write_o[1]), .if_id_write(if_id_write_o[1]), .id_ex_bubble(bubble_o[1]),
        .if_id_flush(flush_o[1]), .stall_reason(reason_o[1]), .md_busy(busy_o[1]),
        .md_done(done_o[1]), .md_overlap_err(err_o[1]), .stall_cnt(cnt_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit reads_reg(input int r);
        return (if_id_use_rs && (int'(if_id_rs) == r)) || (if_id_use_rt && (int'(if_id_rt) == r));
    endfunction

    function automatic bit load_hit();
        return id_ex_memread && (id_ex_rd != 0) && reads_reg(int'(id_ex_rd));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ld_left[i] = 0; m_ld_reg[i] = 0; m_md_left[i] = 0;
            m_done[i] = 0; m_err[i] = 0; m_cnt[i] = 0; e_stall[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            bit lc, mc, ok, st;
            lc = load_hit() || (m_ld_left[i] > 0 && reads_reg(m_ld_reg[i]));
            mc = (m_md_left[i] > 0) && if_id_md_use;
            ok = rst_n && !branch_taken;
            st = ok && (lc || mc);
            e_stall[i] = st;
            chk($sformatf("stall[%0d]", i), stall_o[i], st);
            chk($sformatf("pc_write[%0d]", i), pc_write_o[i], !st);
            chk($sformatf("if_id_write[%0d]", i), if_id_write_o[i], !st);
            chk($sformatf("bubble[%0d]", i), bubble_o[i], st || (rst_n && branch_taken));
            chk($sformatf("flush[%0d]", i), flush_o[i], rst_n && branch_taken);
            chk($sformatf("reason[%0d]", i), reason_o[i], ok ? {mc, lc} : 2'b00);
            chk($sformatf("md_busy[%0d]", i), busy_o[i], m_md_left[i] > 0);
            chk($sformatf("md_done[%0d]", i), done_o[i], m_done[i]);
            chk($sformatf("md_err[%0d]", i), err_o[i], m_err[i]);
            chk($sformatf("stall_cnt[%0d]", i), cnt_o[i], m_cnt[i]);
        end
    endtask

    // Advance to the next falling edge, applying the clock edge to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (cnt_clr) m_cnt[i] = 0;
                else if (e_stall[i] && m_cnt[i] < 15) m_cnt[i]++;
                if (branch_taken) m_ld_left[i] = 0;
                else if (m_ld_left[i] > 0) m_ld_left[i]--;
                else if (load_hit()) begin
                    m_ld_left[i] = ll_p[i] - 1;
                    m_ld_reg[i]  = int'(id_ex_rd);
                end
                m_done[i] = (m_md_left[i] == 1);
                if (m_md_left[i] > 0) begin
                    if (md_start) m_err[i] = 1;
                    m_md_left[i]--;
                end else if (md_start) begin
                    m_md_left[i] = md_p[i];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit mr, input int rd, input int rs, input int rt,
                         input bit urs, input bit urt, input bit mdu,
                         input bit st, input bit br, input bit clr);
        id_ex_memread = mr;     id_ex_rd = AW'(rd);
        if_id_rs      = AW'(rs); if_id_rt = AW'(rt);
        if_id_use_rs  = urs;    if_id_use_rt = urt;
        if_id_md_use  = mdu;    md_start = st;
        branch_taken  = br;     cnt_clr = clr;
    endtask

    task automatic cycle();
        #1 check_all();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        // Reset state, including a hit present while reset is held.
        drive(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);
        #1 check_all();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Load-use on rs, single bubble for LOAD_LAT=1.
        drive(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);
        #1 check_all();
        chk("lat1_stall", stall_o[0], 1'b1);
        chk("lat1_reason", reason_o[0], 2'b01);
        tick();
        drive(0, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        #1 check_all();
        chk("lat1_stall_after", stall_o[0], 1'b0);
        chk("lat1_cnt", cnt_o[0], 4'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle();
        cnt_clr = 0;

        // Load-use on rt with LOAD_LAT=3: three stalled cycles.
        drive(1, 7, 0, 7, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1 check_all();
            chk($sformatf("lat3_stall_c%0d", k), stall_o[1], (k < 3) ? 1'b1 : 1'b0);
            tick();
            id_ex_memread = 0;
        end
        drive(1, 7, 0, 7, 0, 0, 0, 0, 0, 0);
        #1 check_all();
        chk("no_use_rt", stall_o[1], 1'b0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        #1 check_all();
        chk("rd_zero", stall_o[1], 1'b0);
        tick();

        // Mul/div: busy window, done pulse, overlapping issue.
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        md_start = 0;
        for (int k = 1; k <= 8; k++) begin
            md_start = (k == 2);
            #1 check_all();
            chk($sformatf("md_busy_c%0d", k), busy_o[0], (k <= 4) ? 1'b1 : 1'b0);
            chk($sformatf("md_done_c%0d", k), done_o[0], (k == 5) ? 1'b1 : 1'b0);
            if (k == 3) chk("md_overlap", err_o[0], 1'b1);
            tick();
        end

        // Branch during load wait: flush beats stall, wait abandoned.
        drive(1, 7, 0, 7, 0, 1, 0, 0, 0, 0);
        cycle();
        id_ex_memread = 0;
        cycle();
        branch_taken = 1;
        #1 check_all();
        chk("br_stall", stall_o[1], 1'b0);
        chk("br_flush", flush_o[1], 1'b1);
        chk("br_pc_write", pc_write_o[1], 1'b1);
        tick();
        branch_taken = 0;
        #1 check_all();
        chk("br_after", stall_o[1], 1'b0);
        tick();

        // Counter saturation, then clear racing a stalled cycle.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        drive(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cycle();
        #1 chk("cnt_sat", cnt_o[0], 4'd15);
        cnt_clr = 1;
        cycle();
        cnt_clr = 0;
        #1 chk("cnt_clr", cnt_o[0], 4'd0);

        // Reset asserted mid mul/div aborts it with no done pulse.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        md_start = 0;
        cycle();
        cycle();
        rst_n = 0;
        model_reset();
        #1 check_all();
        chk("rst_busy", busy_o[1], 1'b0);
        tick();
        rst_n = 1;
        for (int k = 0; k < 8; k++) cycle();

        // Random traffic over a small register range so hits are frequent.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, range 1..8, total load-use stall cycles.
REQ-003 SHALL have parameter MD_LAT, default 32, range 2..64, mul/div execution cycles.
REQ-004 SHALL have parameter CNT_W, default 16, width of the stall performance counter.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ex_memread  in  1  EX-stage instruction is a load.
- id_ex_rd  in  AW  EX-stage load destination.
- if_id_rs, if_id_rt  in  AW  ID-stage source registers.
- if_id_use_rs, if_id_use_rt  in  1  ID instruction actually reads rs / rt.
- if_id_md_use  in  1  ID instruction is mul/div or reads HI/LO.
- md_start  in  1  EX issues mul/div (single-cycle pulse).
- branch_taken  in  1  EX resolved a taken branch or jump.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall  out  1  hold PC and IF/ID.
- pc_write, if_id_write  out  1  = !stall, except during flush (REQ-015).
- id_ex_bubble  out  1  insert NOP into ID/EX.
- if_id_flush  out  1  squash IF/ID.
- stall_reason  out  2  00 none, 01 load, 10 md, 11 both.
- md_busy, md_done  out  1  mul/div in flight / completion pulse.
- md_overlap_err  out  1  sticky error flag.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-006 SHALL raise a load hit when id_ex_memread=1, id_ex_rd!=0, and id_ex_rd equals a used source (if_id_rs with if_id_use_rs, or if_id_rt with if_id_use_rt); register 0 never hazards.
REQ-007 SHALL assert stall combinationally in the same cycle as a load hit (zero-latency detection).
REQ-008 SHALL use a load FSM with states L_IDLE and L_WAIT: on a hit with LOAD_LAT>1, enter L_WAIT, capture pend_rd=id_ex_rd, and load ld_cnt=LOAD_LAT-1.
REQ-009 In L_WAIT, SHALL assert stall while pend_rd matches a used ID source; SHALL decrement ld_cnt each cycle and return to L_IDLE when ld_cnt reaches 1->0.
REQ-010 With LOAD_LAT=1, the load FSM SHALL never leave L_IDLE (single bubble cycle).
REQ-011 SHALL use an MD FSM with states M_IDLE and M_BUSY: md_start in M_IDLE loads md_cnt=MD_LAT; md_busy=1 in cycles T+1..T+MD_LAT; md_done pulses exactly once, in cycle T+MD_LAT+1.
REQ-012 SHALL ignore md_start while M_BUSY and set md_overlap_err, which holds until reset.
REQ-013 SHALL assert stall when md_busy=1 and if_id_md_use=1.
REQ-014 SHALL drive stall_reason bit0 for a load cause and bit1 for an md cause, both simultaneously when applicable.
REQ-015 On branch_taken=1: if_id_flush=1 and id_ex_bubble=1; stall is forced 0 and pc_write=1 (flush beats stall); the load FSM returns to L_IDLE the same edge; the MD FSM is unaffected.
REQ-016 SHALL drive id_ex_bubble=stall|branch_taken and pc_write=if_id_write=!stall.
REQ-017 SHALL increment stall_cnt each cycle stall=1 and saturate at all-ones; cnt_clr has priority over increment.

Reset
REQ-018 rst_n=0 SHALL asynchronously place both FSMs in idle and clear ld_cnt, md_cnt, pend_rd, stall_cnt, md_done, and md_overlap_err.
REQ-019 During reset, stall=0, pc_write=if_id_write=1, and all other outputs are 0; reset mid-operation SHALL abort any wait with no md_done pulse.

Structure
REQ-020 SHALL place FSM state encodings and the stall_reason codes in shared package hazard_pkg.
REQ-021 SHALL implement the mul/div tracker (md_cnt, md_busy, md_done, md_overlap_err) as sub-module md_tracker; everything else is flat.

Verification
REQ-022 LOAD_LAT=1, load $5 in EX, ID reads rs=$5 -> stall=1 for exactly 1 cycle, stall_reason=01, stall_cnt=1.
REQ-023 LOAD_LAT=3, load $7, ID rt=$7 with use_rt=1 -> stall=1 for 3 consecutive cycles; with use_rt=0 -> no stall; with id_ex_rd=0 -> no stall.
REQ-024 MD_LAT=4, md_start at cycle 10, ID if_id_md_use=1 -> md_busy 11..14, stall 11..14, md_done=1 only at 15; second md_start at 12 -> md_overlap_err=1.
REQ-025 LOAD_LAT=3 wait in progress plus branch_taken in wait cycle 2 -> stall=0, if_id_flush=1, pc_write=1 that cycle, L_IDLE next cycle.
REQ-026 CNT_W=4, 20 stalled cycles -> stall_cnt saturates at 15; cnt_clr together with a stalled cycle -> 0; rst_n pulsed low during M_BUSY -> md_busy=0 immediately, no md_done.
